// File: rtl/osc_pkg.sv
// Shared limits and helpers for the oscillator stand-in blocks.
package osc_pkg;

    localparam int unsigned OSC_FREQ_DIV_MIN = 32'd2;
    localparam int unsigned OSC_FREQ_DIV_MAX = 32'd128;
    localparam int unsigned OSC_STARTUP_MAX  = 32'd255;

    // Number of bits needed to hold any value from 0 up to max_val (at least 1).
    function automatic int unsigned osc_cnt_width(input int unsigned max_val);
        int unsigned width;
        width = 32'd1;
        for (int i = 0; i < 32; i++) begin
            if ((max_val >> i) != 32'd0) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/osc_startup_timer.sv
// Settling timer: counts reference edges after reset release and raises
// osc_ready on the STARTUP_CYCLES-th one. The flag is sticky until reset and
// the counter parks at its terminal value instead of wrapping.
module osc_startup_timer
    import osc_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = 32'd16
)
(
    input  logic clk,
    input  logic reset_n,
    output logic osc_ready
);

    localparam int unsigned            CNT_W      = osc_cnt_width(STARTUP_CYCLES);
    localparam logic [CNT_W-1:0]       START_TERM = CNT_W'(STARTUP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]       CNT_ZERO   = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(32'd1);

    if ((STARTUP_CYCLES < 32'd1) || (STARTUP_CYCLES > OSC_STARTUP_MAX)) begin : g_bad_startup
        $error("osc_startup_timer: STARTUP_CYCLES=%0d outside 1..%0d",
               STARTUP_CYCLES, OSC_STARTUP_MAX);
    end

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ready_r;
    logic             ready_nxt_s;

    // Next-state: count until the terminal edge, then hold with ready set.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        ready_nxt_s = ready_r;
        if (ready_r) begin
            cnt_nxt_s   = cnt_r;
            ready_nxt_s = 1'b1;
        end else if (cnt_r == START_TERM) begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            ready_nxt_s = 1'b1;
        end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            ready_nxt_s = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    assign osc_ready = ready_r;

endmodule

// File: rtl/osc_clock_gen.sv
// Synthesizable stand-in for the on-chip oscillator: divides clk by FREQ_DIV
// into a 50%-duty oscout after a startup settling delay, with glitch-free
// enable gating and a strobe on every oscout rise.
module osc_clock_gen
    import osc_pkg::*;
#(
    parameter int unsigned FREQ_DIV       = 32'd8,
    parameter int unsigned STARTUP_CYCLES = 32'd16
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic oscen,
    output logic oscout,
    output logic osc_ready,
    output logic tick
);

    localparam int unsigned       HALF      = FREQ_DIV / 32'd2;
    localparam int unsigned       HALF_W    = osc_cnt_width(HALF - 32'd1);
    localparam logic [HALF_W-1:0] HALF_TERM = HALF_W'(HALF - 32'd1);
    localparam logic [HALF_W-1:0] CNT_ZERO  = HALF_W'(32'd0);
    localparam logic [HALF_W-1:0] CNT_ONE   = HALF_W'(32'd1);

    if ((FREQ_DIV < OSC_FREQ_DIV_MIN) || (FREQ_DIV > OSC_FREQ_DIV_MAX) ||
        ((FREQ_DIV % 32'd2) != 32'd0)) begin : g_bad_freq_div
        $error("osc_clock_gen: FREQ_DIV=%0d must be even and within %0d..%0d",
               FREQ_DIV, OSC_FREQ_DIV_MIN, OSC_FREQ_DIV_MAX);
    end

    logic              osc_ready_s;
    logic [HALF_W-1:0] half_cnt_r;
    logic [HALF_W-1:0] half_cnt_nxt_s;
    logic              oscout_r;
    logic              oscout_nxt_s;
    logic              tick_r;
    logic              tick_nxt_s;

    osc_startup_timer #(
        .STARTUP_CYCLES (STARTUP_CYCLES)
    ) u_startup (
        .clk       (clk),
        .reset_n   (reset_n),
        .osc_ready (osc_ready_s)
    );

    // Toggle and gating: a high phase always runs to completion, while a
    // disabled low phase parks the counter at zero so re-enabling starts a
    // full-length low phase (no runt pulses in either direction).
    always_comb begin
        half_cnt_nxt_s = half_cnt_r;
        oscout_nxt_s   = oscout_r;
        tick_nxt_s     = 1'b0;
        if (!osc_ready_s) begin
            half_cnt_nxt_s = CNT_ZERO;
            oscout_nxt_s   = 1'b0;
        end else if (oscen || oscout_r) begin
            if (half_cnt_r == HALF_TERM) begin
                half_cnt_nxt_s = CNT_ZERO;
                oscout_nxt_s   = ~oscout_r;
                tick_nxt_s     = ~oscout_r;
            end else begin
                half_cnt_nxt_s = half_cnt_r + CNT_ONE;
            end
        end else begin
            half_cnt_nxt_s = CNT_ZERO;
            oscout_nxt_s   = 1'b0;
        end
    end

    // Output and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            half_cnt_r <= CNT_ZERO;
            oscout_r   <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            half_cnt_r <= half_cnt_nxt_s;
            oscout_r   <= oscout_nxt_s;
            tick_r     <= tick_nxt_s;
        end
    end

    assign oscout    = oscout_r;
    assign osc_ready = osc_ready_s;
    assign tick      = tick_r;

endmodule

// File: tb/tb_osc_clock_gen.sv
// Scoreboard bench for osc_clock_gen. Two instances share one clock:
// dut0 uses the defaults (FREQ_DIV=8, STARTUP_CYCLES=16), dut1 uses
// FREQ_DIV=2, STARTUP_CYCLES=1. Stimulus pushes the expected output events
// (edge number + kind, hand-derived from the timing rules); a monitor on the
// falling edge turns every observed output event into a pop-and-compare.
module tb_osc_clock_gen;

    localparam int EV_RDY_RISE = 0;
    localparam int EV_RDY_FALL = 1;
    localparam int EV_OSC_RISE = 2;
    localparam int EV_TICK     = 3;
    localparam int EV_OSC_FALL = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n0 = 1'b0;
    logic oscen0   = 1'b1;
    logic oscout0, osc_ready0, tick0;
    logic reset_n1 = 1'b0;
    logic oscen1   = 1'b1;
    logic oscout1, osc_ready1, tick1;

    logic prev_osc0 = 1'b0;
    logic prev_rdy0 = 1'b0;
    logic prev_osc1 = 1'b0;
    logic prev_rdy1 = 1'b0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    ev_t q0[$];
    ev_t q1[$];

    osc_clock_gen dut0 (
        .clk       (clk),
        .reset_n   (reset_n0),
        .oscen     (oscen0),
        .oscout    (oscout0),
        .osc_ready (osc_ready0),
        .tick      (tick0)
    );

    osc_clock_gen #(
        .FREQ_DIV       (32'd2),
        .STARTUP_CYCLES (32'd1)
    ) dut1 (
        .clk       (clk),
        .reset_n   (reset_n1),
        .oscen     (oscen1),
        .oscout    (oscout1),
        .osc_ready (osc_ready1),
        .tick      (tick1)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_RDY_RISE: return "ready_rise";
            EV_RDY_FALL: return "ready_fall";
            EV_OSC_RISE: return "osc_rise";
            EV_TICK:     return "tick";
            EV_OSC_FALL: return "osc_fall";
            default:     return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int d, input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic observe(input int d, input int kind);
        ev_t e;
        bit  have;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL dut%0d unexpected_event: saw %s at cycle %0d, required no further event",
                     d, ev_name(kind), cyc);
        end else if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL dut%0d event: saw %s at cycle %0d, required %s at cycle %0d",
                     d, ev_name(kind), cyc, ev_name(e.kind), e.cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Return 1 time unit after posedge number c.
    task automatic after_edge(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output event of each DUT is compared against its queue.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (osc_ready0 === 1'b1 && prev_rdy0 !== 1'b1) observe(0, EV_RDY_RISE);
            if (osc_ready0 !== 1'b1 && prev_rdy0 === 1'b1) observe(0, EV_RDY_FALL);
            if (oscout0 === 1'b1 && prev_osc0 !== 1'b1)    observe(0, EV_OSC_RISE);
            if (tick0 === 1'b1)                            observe(0, EV_TICK);
            if (oscout0 !== 1'b1 && prev_osc0 === 1'b1)    observe(0, EV_OSC_FALL);
            if (osc_ready1 === 1'b1 && prev_rdy1 !== 1'b1) observe(1, EV_RDY_RISE);
            if (osc_ready1 !== 1'b1 && prev_rdy1 === 1'b1) observe(1, EV_RDY_FALL);
            if (oscout1 === 1'b1 && prev_osc1 !== 1'b1)    observe(1, EV_OSC_RISE);
            if (tick1 === 1'b1)                            observe(1, EV_TICK);
            if (oscout1 !== 1'b1 && prev_osc1 === 1'b1)    observe(1, EV_OSC_FALL);
            prev_rdy0 <= osc_ready0;
            prev_osc0 <= oscout0;
            prev_rdy1 <= osc_ready1;
            prev_osc1 <= oscout1;
        end
    end

    initial begin
        ev_t e;
        fork
            begin : stim0
                // Reset on edges 1..5; edge 6 is the first counted startup edge,
                // so ready on edge 21 and the first rise HALF=4 edges later.
                expect_ev(0, EV_RDY_RISE, 21);
                for (int k = 0; k < 4; k++) begin
                    expect_ev(0, EV_OSC_RISE, 25 + 8 * k);
                    expect_ev(0, EV_TICK,     25 + 8 * k);
                    expect_ev(0, EV_OSC_FALL, 29 + 8 * k);
                end
                // oscen dropped after the rise on 49: high phase ends at 53.
                // oscen back for edge 61: rise exactly 4 edges later at 64.
                expect_ev(0, EV_OSC_RISE, 64);
                expect_ev(0, EV_TICK,     64);
                expect_ev(0, EV_OSC_FALL, 68);
                expect_ev(0, EV_OSC_RISE, 72);
                expect_ev(0, EV_TICK,     72);
                // Reset on edge 74 while high; startup restarts on edges 75..90.
                expect_ev(0, EV_RDY_FALL, 74);
                expect_ev(0, EV_OSC_FALL, 74);
                expect_ev(0, EV_RDY_RISE, 90);
                // oscen=0 through startup, raised for edge 101: rise at 104.
                expect_ev(0, EV_OSC_RISE, 104);
                expect_ev(0, EV_TICK,     104);
                expect_ev(0, EV_OSC_FALL, 108);
                expect_ev(0, EV_OSC_RISE, 112);
                expect_ev(0, EV_TICK,     112);
                expect_ev(0, EV_OSC_FALL, 116);

                after_edge(3);
                check_bit("dut0_reset_oscout", oscout0, 1'b0);
                check_bit("dut0_reset_ready",  osc_ready0, 1'b0);
                check_bit("dut0_reset_tick",   tick0, 1'b0);
                after_edge(5);
                reset_n0 = 1'b1;
                after_edge(49);
                oscen0 = 1'b0;
                after_edge(60);
                oscen0 = 1'b1;
                after_edge(73);
                reset_n0 = 1'b0;
                after_edge(74);
                check_bit("dut0_midreset_oscout", oscout0, 1'b0);
                check_bit("dut0_midreset_ready",  osc_ready0, 1'b0);
                check_bit("dut0_midreset_tick",   tick0, 1'b0);
                reset_n0 = 1'b1;
                oscen0   = 1'b0;
                after_edge(100);
                oscen0 = 1'b1;
                after_edge(113);
                oscen0 = 1'b0;
            end
            begin : stim1
                // Reset on edges 1..3; ready on edge 4; toggling every edge.
                expect_ev(1, EV_RDY_RISE, 4);
                for (int c = 5; c <= 19; c += 2) begin
                    expect_ev(1, EV_OSC_RISE, c);
                    expect_ev(1, EV_TICK,     c);
                    expect_ev(1, EV_OSC_FALL, c + 1);
                end
                after_edge(3);
                check_bit("dut1_reset_oscout", oscout1, 1'b0);
                check_bit("dut1_reset_ready",  osc_ready1, 1'b0);
                check_bit("dut1_reset_tick",   tick1, 1'b0);
                reset_n1 = 1'b1;
                // Dropped while high after edge 19: falls on 20, then holds low.
                after_edge(19);
                oscen1 = 1'b0;
            end
        join

        after_edge(125);
        #5;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            while (q0.size() > 0) begin
                e = q0.pop_front();
                $display("FAIL dut0 missing_event: saw nothing, required %s at cycle %0d",
                         ev_name(e.kind), e.cyc);
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                $display("FAIL dut1 missing_event: saw nothing, required %s at cycle %0d",
                         ev_name(e.kind), e.cyc);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_clock_gen.md
Name: osc_clock_gen

Overview:
- Synthesizable, simulatable stand-in for the Gowin on-chip oscillator primitive.
- Derives a divided, 50%-duty clock `oscout` from the system reference clock.
- Adds a settling delay after reset, glitch-free enable gating, and a rising-edge strobe.
- Sits at the top of a design and feeds clock dividers and reset repeaters such as the memory-test path.

Parameters:
- FREQ_DIV, 8: output period in clk cycles. Must be even, range 2..128. Any other value is an elaboration error.
- STARTUP_CYCLES, 16: clk cycles after reset release before the oscillator is ready. Range 1..255.

Ports:
- clk  input  1  reference clock; all logic is on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- oscen  input  1  oscillator enable; active high.
- oscout  output  1  divided clock, registered.
- osc_ready  output  1  high once startup settling is complete.
- tick  output  1  one-clk pulse, high in the cycle in which oscout becomes 1.

Behaviour:
- Reset (reset_n=0 at a clk edge): oscout=0, tick=0, osc_ready=0, half-period counter=0, startup counter=0. Reset mid-operation behaves the same, and the full startup sequence repeats after release.
- Startup:
  - Startup counter increments on each edge with reset_n=1.
  - osc_ready goes 1 on the STARTUP_CYCLES-th such edge and stays 1 until reset.
  - While osc_ready=0: oscout=0, tick=0, and oscen is ignored.
- Toggle:
  - HALF = FREQ_DIV/2.
  - While osc_ready=1 and running, the half counter counts 0..HALF-1.
  - On the edge where the counter equals HALF-1: the counter returns to 0 and oscout inverts.
  - Result: oscout is high for HALF cycles and low for HALF cycles.
  - The first low phase after osc_ready rises is a full HALF cycles long.
  - First oscout rise: HALF edges after the osc_ready edge.
- tick: registered, high exactly in the cycles where oscout transitions 0->1, otherwise 0.
- Enable gating (glitch-free):
  - oscen=0 while oscout=0: counter held at 0, oscout stays 0.
  - oscen=0 while oscout=1: the high phase completes normally, oscout falls on schedule, then holds 0.
  - oscen rising again: a new full-length low phase starts, with the counter counting from 0.
  - No runt pulses under any oscen timing.
- Simultaneous events:
  - reset_n=0 has priority over everything.
  - An oscen change in the same cycle as the counter reaching HALF-1 uses the sampled oscen value per the gating rules above.
- FREQ_DIV=2: oscout toggles every edge, and tick fires every second edge.
- Counter widths are sized from the parameters; no wrap-around beyond the terminal counts.

Decomposition:
- Package osc_pkg holds:
  - OSC_FREQ_DIV_MIN=2
  - OSC_FREQ_DIV_MAX=128
  - OSC_STARTUP_MAX=255
  - a function computing counter width from a maximum value
- One sub-module is natural: osc_startup_timer (counter plus osc_ready flag). The toggle and gating logic stays in the top module.

Test Plan:
- Defaults, reset held 5 cycles then released, oscen=1:
  - osc_ready rises on the 16th edge.
  - oscout rises 4 edges later, then has period 8 (4 high / 4 low).
  - tick is a single-cycle pulse at each rise.
- FREQ_DIV=2, STARTUP_CYCLES=1: oscout toggles every edge after the ready edge, and tick is high every other cycle.
- oscen dropped 1 cycle after oscout rises (FREQ_DIV=8):
  - oscout stays high 3 more cycles, then falls and holds 0.
  - oscen re-raised: oscout rises exactly 4 edges later.
- oscen=0 during startup: osc_ready still rises at cycle 16, and oscout stays 0 until oscen=1.
- reset_n pulsed low for 1 cycle while oscout=1:
  - Next edge gives oscout=0, osc_ready=0, tick=0.
  - Startup repeats with osc_ready after 16 edges.
- FREQ_DIV=7 or 130: elaboration fails.
